// File: rtl/linear_layer_seq.sv
// ============================================================================
// linear_layer_seq : time-multiplexed fixed-point linear layer, one shared MAC
// Rev 1.0
// ============================================================================
`default_nettype none

module linear_layer_seq #(
  parameter int WIDTH = 16,
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int FRAC  = 8,
  parameter int RELU  = 0,
  parameter logic [N_OUT*N_IN*WIDTH-1:0] WEIGHTS_FLAT = '0,
  parameter logic [N_OUT*WIDTH-1:0]      BIAS_FLAT    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*WIDTH-1:0]  in_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_OUT*WIDTH-1:0] out_vec,
  output logic                   busy
);

  localparam int ACC_W = 2*WIDTH + $clog2(N_IN) + 1;
  localparam int SUM_W = ACC_W + 2;
  localparam int R_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int C_W   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam logic [R_W-1:0] R_LAST = R_W'(N_OUT-1);
  localparam logic [C_W-1:0] C_LAST = C_W'(N_IN-1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] w_mem [N_OUT][N_IN];
  logic signed [WIDTH-1:0] b_mem [N_OUT];
  logic signed [WIDTH-1:0] x_q   [N_IN];
  logic signed [WIDTH-1:0] out_q [N_OUT];
  logic [R_W-1:0]          r_q;
  logic [C_W-1:0]          c_q;
  logic [ACC_W-1:0]        acc_q, acc_d;

  // Unpack the flat parameter images: row 0 / column 0 sit at the MSB end.
  generate
    for (genvar gr = 0; gr < N_OUT; gr++) begin : g_row
      assign b_mem[gr] = BIAS_FLAT[(N_OUT-gr)*WIDTH-1 -: WIDTH];
      assign out_vec[gr*WIDTH +: WIDTH] = out_q[gr];
      for (genvar gc = 0; gc < N_IN; gc++) begin : g_col
        assign w_mem[gr][gc] = WEIGHTS_FLAT[(N_OUT*N_IN-(gr*N_IN+gc))*WIDTH-1 -: WIDTH];
      end
    end
  endgenerate

  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   b_cur;
  logic [SUM_W-1:0]          bias_sh;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   shifted;
  logic [WIDTH-1:0]          y;
  logic                      last_col;

  assign prod     = w_mem[r_q][c_q] * x_q[c_q];
  assign b_cur    = b_mem[r_q];
  assign acc_d    = acc_q + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign bias_sh  = {{(SUM_W-WIDTH){b_cur[WIDTH-1]}}, b_cur} << FRAC;
  assign sum      = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                  + {{(SUM_W-2*WIDTH){prod[2*WIDTH-1]}}, prod}
                  + bias_sh;
  assign shifted  = sum >>> FRAC;
  assign last_col = (c_q == C_LAST);

  // Saturate first, then ReLU, so a clamped negative still reads as zero.
  always_comb begin
    y = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      y = SAT_MAX[WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      y = SAT_MIN[WIDTH-1:0];
    end
    if ((RELU != 0) && y[WIDTH-1]) begin
      y = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_valid) state_d = S_COMPUTE;
      S_COMPUTE: if (last_col && (r_q == R_LAST)) state_d = S_DONE;
      S_DONE:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_COMPUTE);
  assign out_valid = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      r_q   <= '0;
      c_q   <= '0;
      for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
      for (int r = 0; r < N_OUT; r++) out_q[r] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_IN; i++) x_q[i] <= in_vec[i*WIDTH +: WIDTH];
            r_q   <= '0;
            c_q   <= '0;
            acc_q <= '0;
          end
        end
        S_COMPUTE: begin
          if (last_col) begin
            out_q[r_q] <= y;
            acc_q      <= '0;
            c_q        <= '0;
            r_q        <= (r_q == R_LAST) ? '0 : r_q + 1'b1;
          end else begin
            acc_q <= acc_d;
            c_q   <= c_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_linear_layer_seq.sv
// ============================================================================
// tb_linear_layer_seq : directed scoreboard bench over several layer shapes
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_linear_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ordy;
  logic iv   [6];
  logic ir   [6];
  logic ovld [6];
  logic bsy  [6];
  logic [63:0] ovec [6];

  logic [63:0] ivec0, ivec1, ivec3, ivec4;
  logic [15:0] ivec2;
  logic [47:0] ivec5;
  wire  [63:0] ov0, ov1, ov3, ov4;
  wire  [15:0] ov2;
  wire  [31:0] ov5;

  assign ovec[0] = ov0;
  assign ovec[1] = ov1;
  assign ovec[2] = {48'd0, ov2};
  assign ovec[3] = ov3;
  assign ovec[4] = ov4;
  assign ovec[5] = {32'd0, ov5};

  localparam logic [255:0] W_IDENT = {16'd256, 48'd0, 16'd0, 16'd256, 32'd0,
                                      32'd0, 16'd256, 16'd0, 48'd0, 16'd256};

  linear_layer_seq #(.WEIGHTS_FLAT(W_IDENT)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_vec(ivec0),
    .out_valid(ovld[0]), .out_ready(ordy), .out_vec(ov0), .busy(bsy[0]));

  linear_layer_seq #(.BIAS_FLAT({4{16'd128}})) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_vec(ivec1),
    .out_valid(ovld[1]), .out_ready(ordy), .out_vec(ov1), .busy(bsy[1]));

  linear_layer_seq #(.N_IN(1), .N_OUT(1), .WEIGHTS_FLAT(16'd1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_vec(ivec2),
    .out_valid(ovld[2]), .out_ready(ordy), .out_vec(ov2), .busy(bsy[2]));

  linear_layer_seq #(.RELU(0), .WEIGHTS_FLAT({16{16'h7FFF}})) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_vec(ivec3),
    .out_valid(ovld[3]), .out_ready(ordy), .out_vec(ov3), .busy(bsy[3]));

  linear_layer_seq #(.RELU(1), .WEIGHTS_FLAT({16{16'h7FFF}})) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]), .in_vec(ivec4),
    .out_valid(ovld[4]), .out_ready(ordy), .out_vec(ov4), .busy(bsy[4]));

  linear_layer_seq #(.N_IN(3), .N_OUT(2),
    .WEIGHTS_FLAT({16'd256, 16'd512, 16'd768, 16'hFF00, 16'd0, 16'd256})) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[5]), .in_ready(ir[5]), .in_vec(ivec5),
    .out_valid(ovld[5]), .out_ready(ordy), .out_vec(ov5), .busy(bsy[5]));

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q [$];

  function automatic logic [63:0] pk4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int id, input logic [63:0] v);
    case (id)
      0: ivec0 = v;
      1: ivec1 = v;
      2: ivec2 = v[15:0];
      3: ivec3 = v;
      4: ivec4 = v;
      default: ivec5 = v[47:0];
    endcase
  endtask

  // Called just after a falling edge; returns 1 ns after the accepting edge.
  task automatic send(input int id, input logic [63:0] v, input logic [63:0] exp, input string tag);
    int n = 0;
    sb_q.push_back(exp);
    set_vec(id, v);
    iv[id] = 1'b1;
    while (!ir[id] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 64'(ir[id]), 64'd1);
    @(posedge clk);
    #1 iv[id] = 1'b0;
  endtask

  task automatic collect(input int id, input int lat, input int busy_exp, input string tag);
    int n = 0;
    int bc = 0;
    logic [63:0] e;
    while (!ovld[id] && n < 300) begin
      if (bsy[id]) bc++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    if (busy_exp >= 0) chk({tag, "_busy_cycles"}, 64'(bc), 64'(busy_exp));
    if (sb_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_out_vec"}, ovec[id], e);
    end
  endtask

  task automatic release_out(input int id, input string tag);
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    chk({tag, "_ready_after_release"}, 64'(ir[id]), 64'd1);
    chk({tag, "_valid_after_release"}, 64'(ovld[id]), 64'd0);
    @(negedge clk);
  endtask

  task automatic txn(input int id, input logic [63:0] v, input logic [63:0] exp,
                     input int lat, input int busy_exp, input string tag);
    send(id, v, exp, tag);
    collect(id, lat, busy_exp, tag);
    release_out(id, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ordy  = 1'b0;
    for (int i = 0; i < 6; i++) iv[i] = 1'b0;
    ivec0 = '0; ivec1 = '0; ivec2 = '0; ivec3 = '0; ivec4 = '0; ivec5 = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready",  64'(ir[0]),   64'd1);
    chk("reset_out_valid", 64'(ovld[0]), 64'd0);
    chk("reset_busy",      64'(bsy[0]),  64'd0);
    chk("reset_out_vec",   ovec[0],      64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    txn(0, pk4(256, -512, 768, 1024), pk4(256, -512, 768, 1024), 16, 16, "identity");
    txn(1, pk4(5, -6, 7, 300), pk4(128, 128, 128, 128), 16, 16, "bias");
    txn(2, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFF, 1, 1, "floor_neg");
    txn(2, 64'd1, 64'd0, 1, 1, "floor_pos");
    txn(2, 64'd512, 64'd2, 1, 1, "one_by_one");
    txn(3, {4{16'h7FFF}}, {4{16'h7FFF}}, 16, -1, "sat_pos");
    txn(3, {4{16'h8001}}, {4{16'h8000}}, 16, -1, "sat_neg");
    txn(4, {4{16'h8001}}, 64'd0, 16, -1, "relu_neg");
    txn(4, {4{16'h7FFF}}, {4{16'h7FFF}}, 16, -1, "relu_pos");
    txn(5, {16'd0, 16'd768, 16'd512, 16'd256}, {32'd0, 16'd512, 16'd3584}, 6, 6, "rect");

    // Backpressure: hold DONE with a new vector waiting
    send(0, pk4(1, 2, 3, 4), pk4(1, 2, 3, 4), "bp_first");
    collect(0, 16, 16, "bp_first");
    @(negedge clk);
    set_vec(0, pk4(100, -3, 0, 32767));
    iv[0] = 1'b1;
    sb_q.push_back(pk4(100, -3, 0, 32767));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_out_vec",  ovec[0],          pk4(1, 2, 3, 4));
      chk("bp_hold_in_ready", 64'(ir[0]),       64'd0);
      chk("bp_hold_valid",    64'(ovld[0]),     64'd1);
    end
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    chk("bp_release_in_ready", 64'(ir[0]),   64'd1);
    chk("bp_release_valid",    64'(ovld[0]), 64'd0);
    @(posedge clk);
    #1 iv[0] = 1'b0;
    chk("bp_next_accepted", 64'(bsy[0]), 64'd1);
    collect(0, 16, 16, "bp_next");
    release_out(0, "bp_next");

    // Reset asserted in the fifth COMPUTE cycle
    send(0, pk4(9, 9, 9, 9), pk4(9, 9, 9, 9), "rst_mid");
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(ovld[0]), 64'd0);
    chk("rst_mid_out_vec",   ovec[0],      64'd0);
    chk("rst_mid_in_ready",  64'(ir[0]),   64'd1);
    chk("rst_mid_busy",      64'(bsy[0]),  64'd0);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(0, pk4(256, -512, 768, 1024), pk4(256, -512, 768, 1024), 16, 16, "after_reset");

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
